// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - request FIFO feeding the MEMCTRL strobe sequencer with a one-entry read-response slot
module mem_req_sequencer #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          busy_o,
    output logic [AW-1:0] addr_o,
    output logic          ce_o,
    output logic          csb_o,
    output logic          web_o,
    output logic          oeb_o,
    output logic [DW-1:0] idata_o,
    input  logic [DW-1:0] odata_i
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP, S_RDWAIT} state_t;

    state_t           state_q, state_d;
    logic [AW+DW:0]   fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic             ready_q;
    logic [7:0]       cnt_q, cnt_d;
    logic             op_we_q, op_we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             ce_q, ce_d, csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
    logic [DW-1:0]    idata_q, idata_d;
    logic             rsp_valid_q;
    logic [DW-1:0]    rsp_rdata_q;
    logic             push, launch, capture, can_issue;
    logic             head_we;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_wdata;

    assign push = req_valid_i && ready_q;
    assign {head_we, head_addr, head_wdata} = fifo_mem[rd_ptr_q];
    // A read may launch on the same edge that hands off the previous response.
    assign can_issue = (count_q != '0) && (head_we || !rsp_valid_q || rsp_ready_i);
    assign count_d   = count_q + (PW+1)'(push) - (PW+1)'(launch);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_we_i, req_addr_i, req_wdata_i};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_we_d = op_we_q;
        addr_d  = addr_q;
        ce_d    = 1'b0;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        oeb_d   = 1'b1;
        idata_d = '0;
        launch  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE:   launch = can_issue;
            S_STROBE: state_d = S_GAP;
            S_GAP: begin
                if (op_we_q) begin
                    launch  = can_issue;
                    state_d = S_IDLE;
                end else if (RD_LAT == 1) begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = 8'(RD_LAT - 2);
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (launch) begin
            state_d = S_STROBE;
            ce_d    = 1'b1;
            csb_d   = 1'b0;
            addr_d  = head_addr;
            op_we_d = head_we;
            web_d   = !head_we;
            oeb_d   = head_we;
            idata_d = head_we ? head_wdata : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            addr_q      <= '0;
            ce_q        <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            idata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(launch);
            count_q  <= count_d;
            ready_q  <= (count_d != FULL);
            cnt_q    <= cnt_d;
            op_we_q  <= op_we_d;
            addr_q   <= addr_d;
            ce_q     <= ce_d;
            csb_q    <= csb_d;
            web_q    <= web_d;
            oeb_q    <= oeb_d;
            idata_q  <= idata_d;
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= odata_i;
            end else if (rsp_valid_q && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign busy_o      = (count_q != '0) || (state_q != S_IDLE);
    assign addr_o      = addr_q;
    assign ce_o        = ce_q;
    assign csb_o       = csb_q;
    assign web_o       = web_q;
    assign oeb_o       = oeb_q;
    assign idata_o     = idata_q;
endmodule
